// File: rtl/pipe_stage_reg_if.sv
// Bundle of valid/data/ctrl signals that enters or leaves a pipeline register.
// The driving side uses the master modport. The receiving side uses the slave modport.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl);
    modport slave  (input  valid, input  data, input  ctrl);
endinterface

// File: rtl/pipe_stage_reg.sv
// DEPTH-stage datapath pipeline register with a valid bit per stage.
// It supports a whole-pipe stall, a flush that turns every stage into a bubble, and occupancy reporting.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    pipe_stage_reg_if.slave       in_if,
    pipe_stage_reg_if.master      out_if,
    output logic                  busy_o,
    output logic [CNT_W-1:0]      count_o
);

    logic              valid_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_q  [DEPTH];
    logic [DATA_W-1:0] data_q  [DEPTH];
    logic              valid_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_d  [DEPTH];
    logic [DATA_W-1:0] data_d  [DEPTH];

    // Ctrl is zeroed whenever a stage loads a bubble.
    // Later stages can then copy ctrl unchanged and no bubble ever carries a write enable.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = '0;
            end
        end else if (!stall_i) begin
            valid_d[0] = in_if.valid;
            ctrl_d[0]  = in_if.valid ? in_if.ctrl : '0;
            data_d[0]  = in_if.data;
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                ctrl_d[i]  = ctrl_q[i-1];
                data_d[i]  = data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctrl_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        count_o = '0;
        busy_o  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            count_o = count_o + CNT_W'(valid_q[i]);
            busy_o  = busy_o | valid_q[i];
        end
    end

    assign out_if.valid = valid_q[DEPTH-1];
    assign out_if.ctrl  = ctrl_q[DEPTH-1];
    assign out_if.data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized scoreboard bench for pipe_stage_reg (DEPTH=3) with directed corner cases.
// The reference model is a fixed-length queue of entries.
module tb_pipe_stage_reg;
    localparam int DEPTH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       busy;
    logic [1:0] count;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) in_if ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) out_if ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .in_if(in_if), .out_if(out_if), .busy_o(busy), .count_o(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic v; logic [7:0] c; logic [31:0] d; } ent_t;
    typedef struct { logic v; logic [7:0] c; logic [31:0] d; int cnt; } exp_t;

    ent_t pipe[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   watch55 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        ent_t z;
        z.v = 1'b0; z.c = '0; z.d = '0;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
    endfunction

    function automatic exp_t model_out();
        exp_t o;
        o.v = pipe[DEPTH-1].v; o.c = pipe[DEPTH-1].c; o.d = pipe[DEPTH-1].d; o.cnt = 0;
        foreach (pipe[i]) if (pipe[i].v) o.cnt++;
        return o;
    endfunction

    // One rising edge applied to the model.
    // The priority is reset, then flush, then stall, then advance.
    function automatic void model_edge();
        ent_t e;
        if (rst) model_clear();
        else if (flush) begin
            foreach (pipe[i]) begin pipe[i].v = 1'b0; pipe[i].c = '0; end
        end else if (!stall) begin
            e.v = in_if.valid;
            e.c = in_if.valid ? in_if.ctrl : 8'h00;
            e.d = in_if.data;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endfunction

    // Called at a negedge: drive, take one posedge, record expected outputs, return at next negedge.
    task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic s = 1'b0, input logic f = 1'b0);
        in_if.valid = v; in_if.data = d; in_if.ctrl = c; stall = s; flush = f;
        @(posedge clk);
        #1;
        model_edge();
        sb.push_back(model_out());
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("async_rst valid_o", 32'(out_if.valid), 32'd0);
        chk("async_rst ctrl_o", 32'(out_if.ctrl), 32'd0);
        chk("async_rst data_o", out_if.data, 32'd0);
        chk("async_rst count_o", 32'(count), 32'd0);
        chk("async_rst busy_o", 32'(busy), 32'd0);
        model_clear();
        @(negedge clk);
        step(1'b1, 32'hDEAD, 8'h5A);
        step(1'b1, 32'hBEEF, 8'hA5);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("mon valid_o", 32'(out_if.valid), 32'(e.v));
            chk("mon ctrl_o", 32'(out_if.ctrl), 32'(e.c));
            chk("mon count_o", 32'(count), 32'(e.cnt));
            chk("mon busy_o", 32'(busy), 32'(e.cnt != 0));
            if (e.v) chk("mon data_o", out_if.data, e.d);
        end
        if (watch55 && out_if.valid && out_if.data == 32'h55)
            chk("flushed 0x55 leaked", 32'h55, 32'h0);
    end

    initial begin
        int s_cnt;
        model_clear();
        in_if.valid = 1'b0; in_if.data = '0; in_if.ctrl = '0;
        #1;
        chk("reset valid_o", 32'(out_if.valid), 32'd0);
        chk("reset count_o", 32'(count), 32'd0);
        chk("reset data_o", out_if.data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency and throughput.
        step(1'b1, 32'h10, 8'h01);
        step(1'b1, 32'h11, 8'h02);
        step(1'b1, 32'h12, 8'h03);
        chk("lat data_o@3", out_if.data, 32'h10);
        chk("lat count@3", 32'(count), 32'd3);
        step(1'b0, 32'h0, 8'h0);
        chk("lat data_o@4", out_if.data, 32'h11);
        step(1'b0, 32'h0, 8'h0);
        chk("lat data_o@5", out_if.data, 32'h12);
        step(1'b0, 32'h0, 8'h0);
        chk("lat count drained", 32'(count), 32'd0);

        // Async reset with entries in flight, then three idle cycles with everything at zero.
        step(1'b1, 32'h21, 8'h11);
        step(1'b1, 32'h22, 8'h12);
        async_reset();
        repeat (3) step(1'b0, 32'h0, 8'h0);

        // Stall holds the whole pipe.
        step(1'b1, 32'hA0, 8'h01);
        step(1'b1, 32'hA1, 8'h02);
        step(1'b1, 32'hA2, 8'h03);
        repeat (4) begin
            step(1'b1, 32'hEE, 8'hEE, 1'b1, 1'b0);
            chk("stall data_o", out_if.data, 32'hA0);
            chk("stall count_o", 32'(count), 32'd3);
        end
        step(1'b0, 32'h0, 8'h0);
        chk("stall release data_o", out_if.data, 32'hA1);

        // Flush wins over stall.
        repeat (3) step(1'b1, 32'hC0, 8'hFF);
        step(1'b1, 32'hC1, 8'hFF, 1'b1, 1'b1);
        chk("flush+stall valid_o", 32'(out_if.valid), 32'd0);
        chk("flush+stall ctrl_o", 32'(out_if.ctrl), 32'd0);
        chk("flush+stall count_o", 32'(count), 32'd0);
        chk("flush+stall busy_o", 32'(busy), 32'd0);

        // A bubble presented with ctrl set must come out with ctrl zero.
        step(1'b0, 32'hB0, 8'hFF);
        repeat (DEPTH - 1) step(1'b0, 32'hB1, 8'hFF);
        chk("bubble valid_o", 32'(out_if.valid), 32'd0);
        chk("bubble ctrl_o", 32'(out_if.ctrl), 32'd0);

        // An instruction presented during flush is dropped.
        watch55 = 1'b1;
        step(1'b1, 32'h55, 8'h77);
        step(1'b1, 32'h55, 8'h77, 1'b0, 1'b1);
        repeat (DEPTH + 1) step(1'b0, 32'h0, 8'h0);
        watch55 = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            s_cnt = $urandom_range(0, 99);
            step(1'($urandom_range(0, 1)), $urandom, 8'($urandom),
                 1'(s_cnt < 20), 1'(s_cnt >= 95));
        end

        @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
